// File: rtl/t_pulse_gen_pkg.sv
// rtl/t_pulse_gen_pkg.sv - shared state encoding and default widths for t_pulse_gen
package t_pulse_gen_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_BURST_W = 4;

endpackage

// File: rtl/t_phase_counter.sv
// rtl/t_phase_counter.sv - loadable down-counter timing one ON/OFF phase
module t_phase_counter
  import t_pulse_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Holds at zero so a phase end is seen for exactly one cycle before reload
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/t_pulse_gen.sv
// rtl/t_pulse_gen.sv - burst generator for T_flip_flop.t; T_PULSE_GEN_CONTINUOUS_EN makes bursts=0 run forever
module t_pulse_gen
  import t_pulse_gen_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [CNT_W-1:0]   i_on_cycles,
  input  logic [CNT_W-1:0]   i_off_cycles,
  input  logic [BURST_W-1:0] i_bursts,
  output logic               o_t,
  output logic               o_busy,
  output logic               o_done,
  output logic [BURST_W-1:0] o_burst_idx
);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_on;
  logic [CNT_W-1:0]   r_off;
  logic [BURST_W-1:0] r_bursts;
  logic [BURST_W-1:0] r_idx;
  logic               r_t;
  logic               r_done;

  logic [1:0]         w_state_nxt;
  logic [BURST_W-1:0] w_idx_nxt;
  logic               w_done_nxt;
  logic               w_latch;
  logic               w_load;
  logic [CNT_W-1:0]   w_load_val;
  logic               w_zero;
  logic               w_burst_end;
  logic               w_last;
  logic               w_zero_run;
  logic [CNT_W-1:0]   w_start_on_m1;
  logic [CNT_W-1:0]   w_on_m1;

  assign w_start_on_m1 = (i_on_cycles == '0) ? '0 : i_on_cycles - CNT_W'(1);
  assign w_on_m1       = (r_on == '0) ? '0 : r_on - CNT_W'(1);

`ifdef T_PULSE_GEN_CONTINUOUS_EN
  assign w_zero_run = 1'b0;
  assign w_last     = (r_bursts != '0) && (r_idx == r_bursts - BURST_W'(1));
`else
  assign w_zero_run = (i_bursts == '0);
  assign w_last     = (r_idx == r_bursts - BURST_W'(1));
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    w_latch     = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_burst_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          w_latch = 1'b1;
          if (w_zero_run) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_ON;
            w_idx_nxt   = '0;
            w_load      = 1'b1;
            w_load_val  = w_start_on_m1;
          end
        end
      end
      ST_ON: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end else if (w_zero) begin
          if (r_off != '0) begin
            w_state_nxt = ST_OFF;
            w_load      = 1'b1;
            w_load_val  = r_off - CNT_W'(1);
          end else begin
            w_burst_end = 1'b1;
          end
        end
      end
      ST_OFF: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end else if (w_zero) begin
          w_burst_end = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
    if (w_burst_end) begin
      if (w_last) begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = ST_ON;
        w_idx_nxt   = r_idx + BURST_W'(1);
        w_load      = 1'b1;
        w_load_val  = w_on_m1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= ST_IDLE;
      r_on     <= '0;
      r_off    <= '0;
      r_bursts <= '0;
      r_idx    <= '0;
      r_t      <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_t     <= (w_state_nxt == ST_ON);
      r_done  <= w_done_nxt;
      if (w_latch) begin
        r_on     <= i_on_cycles;
        r_off    <= i_off_cycles;
        r_bursts <= i_bursts;
      end
    end
  end

  t_phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (o_busy),
    .o_zero     (w_zero)
  );

  assign o_t         = r_t;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = r_done;
  assign o_burst_idx = r_idx;

endmodule

// File: doc/t_pulse_gen.md
# t_pulse_gen

Programmable burst generator that drives the `t` input of the downstream `T_flip_flop` stage. On a start request it emits `bursts` repetitions of a pattern: `t` high for `on_cycles` clocks, then low for `off_cycles` clocks. It reports progress with `busy`, `burst_idx` and a one-cycle `done` pulse. It replaces hand-written `t` stimulus with a synthesizable, cycle-exact sequencer.

## Interface
- `CNT_W`, 8, width of the on/off phase lengths
- `BURST_W`, 4, width of the burst count and index
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  launch request; sampled only in IDLE
- `abort`  in  1  terminate the current run
- `on_cycles`  in  CNT_W  length of the high phase, latched on start
- `off_cycles`  in  CNT_W  length of the low phase, latched on start
- `bursts`  in  BURST_W  number of repetitions, latched on start
- `t`  out  1  registered pulse output to `T_flip_flop.t`
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse on normal completion
- `burst_idx`  out  BURST_W  0-based index of the burst in progress

## Operation
- States: IDLE, ON, OFF.
- IDLE, `start`=1, `abort`=0:
  - Latch the configuration.
  - If `bursts`=0: stay in IDLE and pulse `done` (non-continuous build, see Configuration).
  - Otherwise go to ON with `burst_idx`=0.
- ON:
  - `t`=1 for max(`on_cycles`,1) cycles; `on_cycles`=0 is treated as 1.
  - Then go to OFF if the latched `off_cycles`>0.
  - Otherwise the burst ends immediately.
- OFF: `t`=0 for `off_cycles` cycles, then the burst ends.
- Burst end:
  - If `burst_idx`=`bursts`-1: go to IDLE with `done`=1 for one cycle.
  - Otherwise increment `burst_idx` and go to ON.
- With `off_cycles`=0, `t` stays high continuously across burst boundaries.
- `abort`=1 in ON or OFF: go to IDLE at the next edge. `t`=0, `busy`=0, `burst_idx`=0, and no `done` pulse.
- `abort` has priority over `start`. `abort` in IDLE has no effect.
- `start` while `busy`=1 is ignored. The input configuration may change freely while busy.
- `start` in the same cycle `done`=1 is accepted, since the FSM is already in IDLE. This allows back-to-back runs.
- `busy` = (state != IDLE). `burst_idx` is 0 in IDLE.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, `t`=0, `busy`=0, `done`=0, `burst_idx`=0, latched configuration cleared. Asserting reset mid-run truncates the run immediately, with no `done`.
- Let edge E0 be the edge that samples `start`. After E0: `t`=1, `busy`=1.
- With n = max(`on_cycles`,1), m = `off_cycles`, b = `bursts`:
  - `t` falls at E0+n and rises again at E0+(n+m), when m>0.
  - At E0+b·(n+m): `t`=0, `busy`=0, `done`=1 for exactly one cycle.
- `bursts`=0 (non-continuous): after E0, `done`=1 for one cycle. `busy` and `t` stay 0.
- Abort sampled at edge Ea: after Ea, `t`=0 and `busy`=0.
- Phase counters are down-counters of CNT_W bits loaded with length-1. The maximum phase length is 2^CNT_W-1 cycles. There is no overflow path.

## Configuration
- Macro: `T_PULSE_GEN_CONTINUOUS_EN`.
- Defined:
  - `bursts`=0 runs the ON/OFF pattern indefinitely until `abort` or reset.
  - `done` never pulses in that mode.
  - `burst_idx` increments and wraps modulo 2^BURST_W.
- Undefined: `bursts`=0 completes immediately as described in Timing, and `burst_idx` never wraps.

## Structure
- Shared package `t_pulse_gen_pkg`:
  - State encoding localparams ST_IDLE=2'd0, ST_ON=2'd1, ST_OFF=2'd2.
  - Default widths CNT_W=8, BURST_W=4.
- Sub-module `t_phase_counter`: CNT_W-bit loadable down-counter with `load`, `load_val`, `en` and a `zero` flag. It is instantiated once and reloaded at each phase change.

## Test plan
- Reset mid-run: `on`=3, `off`=3, `bursts`=4; drop `rst` during burst 1 -> same cycle `t`=0, `busy`=0, `burst_idx`=0, no `done`.
- Pattern: 10 ns clock, `on`=2, `off`=4, `bursts`=5 -> `t` high 2 / low 4, five times; `done` at E0+30; downstream `T_flip_flop` q toggles on the 10 high cycles.
- Degenerate lengths: `on`=0, `off`=0, `bursts`=3 -> `t` high for exactly 3 cycles, `done` at E0+3.
- Zero bursts: undefined macro -> `done` after E0, `t` never 1; defined macro, `on`=1, `off`=1 -> alternating `t` for 40 cycles, `burst_idx` wraps 15->0, abort stops it, no `done`.
- Abort/start conflicts: abort in OFF of burst 2 -> idle next edge, no `done`; `start`+`abort` together in IDLE -> stays idle; `start` while busy -> ignored.
- Back-to-back: reassert `start` in the `done` cycle with `on`=1, `off`=2, `bursts`=2 -> `t` rises the next cycle, second `done` at +6.
